// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, cycle-count helpers and
// the keyboard command/response bytes used by the receiver and scan-event code.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE
    } tx_state_t;

    localparam int DEFAULT_CLK_HZ     = 50_000_000;
    localparam int DEFAULT_INHIBIT_US = 100;
    localparam int DEFAULT_TIMEOUT_US = 15_000;

    function automatic int us_to_cycles(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    localparam int INHIBIT_CYCLES = us_to_cycles(DEFAULT_CLK_HZ, DEFAULT_INHIBIT_US);
    localparam int TIMEOUT_CYCLES = us_to_cycles(DEFAULT_CLK_HZ, DEFAULT_TIMEOUT_US);

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 pin plus a falling-edge detector.
// Registers reset to the idle-high bus level so reset never fakes an edge.
module ps2_sync_edge (
    input  logic clk,
    input  logic srst,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= pin;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits + odd parity +
// stop, device ack check and timeout. Optional resend via `PS2_TX_RETRY_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int INHIBIT_US = DEFAULT_INHIBIT_US,
    parameter int TIMEOUT_US = DEFAULT_TIMEOUT_US
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int MAX_RETRY  = 2
`endif
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
`ifdef PS2_TX_RETRY_EN
    ,
    output logic [1:0] retry_cnt
`endif
);

    localparam int INH_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int TMO_CYC = us_to_cycles(CLK_HZ, TIMEOUT_US);
    localparam int INH_W   = (INH_CYC > 2) ? $clog2(INH_CYC) : 1;
    localparam int TMO_W   = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
`ifdef PS2_TX_RETRY_EN
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
`endif

    logic clk_level;
    logic clk_fall;
    logic dat_level;
    logic dat_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk   (CLOCK_50),
        .srst  (reset),
        .pin   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk   (CLOCK_50),
        .srst  (reset),
        .pin   (ps2_dat_in),
        .level (dat_level),
        .fall  (dat_fall_unused)
    );

    tx_state_t        state_reg,   state_next;
    logic [7:0]       data_reg,    data_next;
    logic             parity_reg,  parity_next;
    logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic             dat_bit_reg, dat_bit_next;
    logic             ack_reg,     ack_next;
    logic             done_reg,    done_next;
    logic             ack_ok_reg,  ack_ok_next;
    logic             err_reg,     err_next;
    logic             attempt_pass;
    logic             attempt_fail;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]       retry_reg,   retry_next;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg   <= IDLE;
            data_reg    <= '0;
            parity_reg  <= 1'b0;
            inh_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            dat_bit_reg <= 1'b0;
            ack_reg     <= 1'b0;
            done_reg    <= 1'b0;
            ack_ok_reg  <= 1'b0;
            err_reg     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_reg   <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            parity_reg  <= parity_next;
            inh_cnt_reg <= inh_cnt_next;
            tmo_cnt_reg <= tmo_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            dat_bit_reg <= dat_bit_next;
            ack_reg     <= ack_next;
            done_reg    <= done_next;
            ack_ok_reg  <= ack_ok_next;
            err_reg     <= err_next;
`ifdef PS2_TX_RETRY_EN
            retry_reg   <= retry_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        parity_next  = parity_reg;
        inh_cnt_next = inh_cnt_reg;
        tmo_cnt_next = tmo_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        dat_bit_next = dat_bit_reg;
        ack_next     = ack_reg;
        done_next    = 1'b0;
        ack_ok_next  = 1'b0;
        err_next     = 1'b0;
        attempt_pass = 1'b0;
        attempt_fail = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_next   = retry_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    data_next    = tx_data;
                    parity_next  = ~^tx_data;
                    inh_cnt_next = '0;
                    state_next   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_next   = '0;
`endif
                end
            end
            INHIBIT: begin
                if (inh_cnt_reg == INH_LAST) begin
                    inh_cnt_next = '0;
                    state_next   = START;
                end else begin
                    inh_cnt_next = inh_cnt_reg + 1'b1;
                end
            end
            START: begin
                state_next   = SEND;
                tmo_cnt_next = '0;
                bit_cnt_next = '0;
                dat_bit_next = 1'b1;
            end
            SEND, ACK, WAIT_IDLE: begin
                // Timeout is checked first so it wins over a coincident edge.
                if (tmo_cnt_reg == TMO_LAST) begin
                    attempt_fail = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                    if (state_reg == SEND && clk_fall) begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg < 4'd8) begin
                            dat_bit_next = ~data_reg[bit_cnt_reg[2:0]];
                        end else if (bit_cnt_reg == 4'd8) begin
                            dat_bit_next = ~parity_reg;
                        end else begin
                            dat_bit_next = 1'b0;
                            state_next   = ACK;
                        end
                    end else if (state_reg == ACK && clk_fall) begin
                        ack_next   = ~dat_level;
                        state_next = WAIT_IDLE;
                    end else if (state_reg == WAIT_IDLE && clk_level && dat_level) begin
                        if (ack_reg) begin
                            attempt_pass = 1'b1;
                        end else begin
                            attempt_fail = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (attempt_pass) begin
            state_next  = IDLE;
            done_next   = 1'b1;
            ack_ok_next = 1'b1;
        end

        if (attempt_fail) begin
`ifdef PS2_TX_RETRY_EN
            if (retry_reg < RETRY_LIMIT) begin
                retry_next   = retry_reg + 2'd1;
                inh_cnt_next = '0;
                state_next   = INHIBIT;
            end else
`endif
            begin
                state_next = IDLE;
                done_next  = 1'b1;
                err_next   = 1'b1;
            end
        end
    end

    assign tx_ready   = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign ps2_clk_oe = (state_reg == INHIBIT) || (state_reg == START);
    assign ps2_dat_oe = (state_reg == START) || ((state_reg == SEND) && dat_bit_reg);
    assign done       = done_reg;
    assign ack_ok     = ack_ok_reg;
    assign err        = err_reg;
`ifdef PS2_TX_RETRY_EN
    assign retry_cnt  = retry_reg;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 keyboard model.
// Honours `PS2_TX_RETRY_EN when the design is built with it.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_HZ     = 1_000_000;
    localparam int INHIBIT_US = 100;
    localparam int TIMEOUT_US = 3000;
    localparam int INH_CYC    = (CLK_HZ / 1_000_000) * INHIBIT_US;
    localparam int TMO_CYC    = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    // 12.5 kHz device clock at a 1 MHz system clock: 80 cycles per period.
    localparam int HALF       = 40;
`ifdef PS2_TX_RETRY_EN
    localparam int MAX_RETRY  = 2;
    localparam int ATTEMPTS   = MAX_RETRY + 1;
`else
    localparam int ATTEMPTS   = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       clk_oe;
    logic       dat_oe;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err;
`ifdef PS2_TX_RETRY_EN
    logic [1:0] retry_cnt;
`endif
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    always #5 clk = ~clk;

    assign ps2_clk_in = dev_clk & ~clk_oe;
    assign ps2_dat_in = dev_dat & ~dat_oe;

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_US (TIMEOUT_US)
`ifdef PS2_TX_RETRY_EN
        ,
        .MAX_RETRY  (MAX_RETRY)
`endif
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (clk_oe),
        .ps2_dat_oe (dat_oe),
        .busy       (busy),
        .done       (done),
        .ack_ok     (ack_ok),
        .err        (err)
`ifdef PS2_TX_RETRY_EN
        ,
        .retry_cnt  (retry_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wire image of a frame: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = (b >> i) & 8'd1;
        f[8] = ($countones(b) % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_before_send", {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic dev_frame(input int edges, input bit give_ack, output logic [9:0] seen);
        bit req;
        req  = 1'b0;
        seen = '0;
        for (int i = 0; i < 4 * (INH_CYC + 10); i++) begin
            @(negedge clk);
            if (clk_oe === 1'b0 && dat_oe === 1'b1) begin
                req = 1'b1;
                break;
            end
        end
        chk("dev_request_seen", {31'd0, req}, 32'd1);
        if (req) begin
            repeat (HALF) @(negedge clk);
            for (int e = 0; e < edges; e++) begin
                if (e == 10 && give_ack) dev_dat = 1'b0;
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                if (e < 10) seen[e] = ps2_dat_in;
                dev_clk = 1'b1;
                repeat (HALF) @(negedge clk);
            end
            dev_dat = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget, output int since_rel, output logic ok,
                             output logic er, output int inh, output int st, output int viol);
        int   n;
        int   rel;
        bit   seen;
        logic prev_oe;
        rel = 0; seen = 1'b0; prev_oe = 1'b0;
        inh = 0; st = 0; viol = 0; ok = 1'bx; er = 1'bx;
        for (n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (clk_oe && !dat_oe) inh++;
            if (clk_oe && dat_oe) st++;
            if (prev_oe && !clk_oe) rel = n;
            prev_oe = clk_oe;
            if (busy && tx_ready) viol++;
            if (done === 1'b1) begin
                seen = 1'b1;
                ok   = ack_ok;
                er   = err;
                break;
            end
        end
        since_rel = n - rel;
        chk("done_within_budget", {31'd0, seen}, 32'd1);
    endtask

    task automatic do_xfer(input logic [7:0] b, input bit dev_on, input bit give_ack,
                           output logic [9:0] bits, output int since_rel, output logic ok,
                           output logic er, output int inh, output int st, output int viol);
        int budget;
        budget = ATTEMPTS * (INH_CYC + TMO_CYC + 20) + 200;
        bits = '0;
        send(b);
        fork
            begin
                if (dev_on)
                    for (int a = 0; a < (give_ack ? 1 : ATTEMPTS); a++)
                        dev_frame(11, give_ack, bits);
            end
            wait_done(budget, since_rel, ok, er, inh, st, viol);
        join
        $display("xfer data=%02h wire=%03h ack_ok=%0b err=%0b since_release=%0d", b, bits, ok, er, since_rel);
    endtask

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [9:0]  bits;
    int          since_rel, inh, st, viol;
    logic        ok, er;
    logic [7:0]  bytes [6];

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_clk_oe", {31'd0, clk_oe}, 32'd0);
        chk("reset_dat_oe", {31'd0, dat_oe}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
`ifdef PS2_TX_RETRY_EN
        chk("reset_retry_cnt", {30'd0, retry_cnt}, 32'd0);
`endif

        // Acknowledged transfers: directed commands plus random bytes.
        bytes[0] = CMD_SET_LED;
        bytes[1] = 8'h00;
        bytes[2] = 8'h01;
        for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            do_xfer(bytes[i], 1'b1, 1'b1, bits, since_rel, ok, er, inh, st, viol);
            chk("ack_frame_bits", {22'd0, bits}, {22'd0, frame_of(bytes[i])});
            chk("ack_ack_ok", {31'd0, ok}, 32'd1);
            chk("ack_err", {31'd0, er}, 32'd0);
            chk("ack_inhibit_cycles", inh, INH_CYC);
            chk("ack_start_cycles", st, 1);
            chk("ack_ready_while_busy", viol, 0);
`ifdef PS2_TX_RETRY_EN
            chk("ack_retry_cnt", {30'd0, retry_cnt}, 32'd0);
`endif
        end

        // Device never acknowledges.
        do_xfer(CMD_ENABLE, 1'b1, 1'b0, bits, since_rel, ok, er, inh, st, viol);
        chk("noack_frame_bits", {22'd0, bits}, {22'd0, frame_of(CMD_ENABLE)});
        chk("noack_ack_ok", {31'd0, ok}, 32'd0);
        chk("noack_err", {31'd0, er}, 32'd1);
`ifdef PS2_TX_RETRY_EN
        chk("noack_retry_cnt", {30'd0, retry_cnt}, MAX_RETRY);
`endif
        repeat (2 * HALF) @(negedge clk);

        // Device never clocks: timeout measured from the last clock release.
        do_xfer(CMD_RESET, 1'b0, 1'b0, bits, since_rel, ok, er, inh, st, viol);
        chk("timeout_cycles", since_rel, TMO_CYC);
        chk("timeout_err", {31'd0, er}, 32'd1);
        chk("timeout_ack_ok", {31'd0, ok}, 32'd0);
        chk("timeout_clk_oe", {31'd0, clk_oe}, 32'd0);
        chk("timeout_dat_oe", {31'd0, dat_oe}, 32'd0);

        // tx_valid held high with a second byte waiting behind the first.
        bytes[0] = 8'($urandom);
        bytes[1] = 8'($urandom);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = bytes[0];
        @(posedge clk);
        #1 tx_data = bytes[1];
        fork
            dev_frame(11, 1'b1, bits);
            wait_done(INH_CYC + TMO_CYC + 200, since_rel, ok, er, inh, st, viol);
        join
        $display("xfer data=%02h wire=%03h ack_ok=%0b err=%0b held_valid", bytes[0], bits, ok, er);
        chk("held_first_bits", {22'd0, bits}, {22'd0, frame_of(bytes[0])});
        chk("held_ready_while_busy", viol, 0);
        chk("held_ready_at_done", {31'd0, tx_ready}, 32'd1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        chk("held_second_accepted", {31'd0, busy}, 32'd1);
        fork
            dev_frame(11, 1'b1, bits);
            wait_done(INH_CYC + TMO_CYC + 200, since_rel, ok, er, inh, st, viol);
        join
        $display("xfer data=%02h wire=%03h ack_ok=%0b err=%0b held_valid", bytes[1], bits, ok, er);
        chk("held_second_bits", {22'd0, bits}, {22'd0, frame_of(bytes[1])});
        chk("held_second_ack_ok", {31'd0, ok}, 32'd1);

        // Reset while bit 4 is on the wire.
        send(8'h5A);
        dev_frame(5, 1'b0, bits);
        reset = 1'b1;
        @(negedge clk);
        $display("xfer data=5a aborted by reset");
        chk("midreset_clk_oe", {31'd0, clk_oe}, 32'd0);
        chk("midreset_dat_oe", {31'd0, dat_oe}, 32'd0);
        chk("midreset_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("midreset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0) viol++;
        end
        chk("midreset_no_done", viol, 0);
        do_xfer(CMD_RESET, 1'b1, 1'b1, bits, since_rel, ok, er, inh, st, viol);
        chk("after_reset_bits", {22'd0, bits}, {22'd0, frame_of(CMD_RESET)});
        chk("after_reset_ack_ok", {31'd0, ok}, 32'd1);
        chk("after_reset_err", {31'd0, er}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
